seven_segment_decoder: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 39 +++
 rtl/seven_segment_decoder_hex_to_seg.sv | 33 +++
 rtl/seven_segment_decoder.sv | 45 ++++
 tb/tb_seven_segment_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment decoder: segment bit positions,
// the active-high hex glyph table and the polarity helper.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_ALL = 7'b1111111;

  // Active-high glyphs, abcdefg order, indexed by nibble value.
  localparam logic [SEG_W-1:0] SEG_PATTERNS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [SEG_W-1:0] seg_apply_polarity(
    input logic [SEG_W-1:0] pattern,
    input logic             active_low
  );
    logic [SEG_W-1:0] mask;
    if (active_low) begin
      mask = SEG_ALL;
    end else begin
      mask = SEG_OFF;
    end
    return pattern ^ mask;
  endfunction

endpackage

// File: rtl/seven_segment_decoder_hex_to_seg.sv
// Combinational nibble-to-glyph lookup; output is always the active-high pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  // Full 16-entry decode; default only exists for structural completeness.
  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'd0:    seg_o = SEG_PATTERNS[0];
      4'd1:    seg_o = SEG_PATTERNS[1];
      4'd2:    seg_o = SEG_PATTERNS[2];
      4'd3:    seg_o = SEG_PATTERNS[3];
      4'd4:    seg_o = SEG_PATTERNS[4];
      4'd5:    seg_o = SEG_PATTERNS[5];
      4'd6:    seg_o = SEG_PATTERNS[6];
      4'd7:    seg_o = SEG_PATTERNS[7];
      4'd8:    seg_o = SEG_PATTERNS[8];
      4'd9:    seg_o = SEG_PATTERNS[9];
      4'd10:   seg_o = SEG_PATTERNS[10];
      4'd11:   seg_o = SEG_PATTERNS[11];
      4'd12:   seg_o = SEG_PATTERNS[12];
      4'd13:   seg_o = SEG_PATTERNS[13];
      4'd14:   seg_o = SEG_PATTERNS[14];
      4'd15:   seg_o = SEG_PATTERNS[15];
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Registered hex digit to seven-segment driver with blanking and
// selectable common-cathode / common-anode output polarity.
module seven_segment_decoder
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       seg_in,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_out
);

  logic [SEG_W-1:0] glyph_s;
  logic [SEG_W-1:0] seg_d;
  logic [SEG_W-1:0] seg_q;

  hex_to_seg u_hex_to_seg (
    .nibble_i (seg_in),
    .seg_o    (glyph_s)
  );

  // Blank first, then invert, so "off" is unlit for either display type.
  always_comb begin
    seg_d = seg_apply_polarity(SEG_OFF, ACTIVE_LOW);
    if (blank) begin
      seg_d = seg_apply_polarity(SEG_OFF, ACTIVE_LOW);
    end else begin
      seg_d = seg_apply_polarity(glyph_s, ACTIVE_LOW);
    end
  end

  // Output register; reset outranks blank and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= seg_apply_polarity(SEG_OFF, ACTIVE_LOW);
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_out = seg_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench: one decoder per polarity sharing the same stimulus,
// compared against a glyph model built from lit-segment letter lists.
module tb_seven_segment_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] seg_in;
  logic       blank;
  logic [6:0] seg_out_cc;
  logic [6:0] seg_out_ca;

  int total;
  int bad;

  seven_segment_decoder #(.ACTIVE_LOW(1'b0)) dut_cc (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .blank   (blank),
    .seg_out (seg_out_cc)
  );

  seven_segment_decoder #(.ACTIVE_LOW(1'b1)) dut_ca (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .blank   (blank),
    .seg_out (seg_out_ca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which segments light up for each hex digit, named by letter.
  function automatic string lit_segments(input int v);
    case (v)
      0:  return "abcdef";
      1:  return "bc";
      2:  return "abdeg";
      3:  return "abcdg";
      4:  return "bcfg";
      5:  return "acdfg";
      6:  return "acdefg";
      7:  return "abc";
      8:  return "abcdefg";
      9:  return "abcdfg";
      10: return "abcefg";
      11: return "cdefg";
      12: return "adef";
      13: return "bcdeg";
      14: return "adefg";
      15: return "aefg";
      default: return "";
    endcase
  endfunction

  // Segment 'a' is bit 6 down to 'g' at bit 0.
  function automatic logic [6:0] glyph(input int v);
    string s;
    logic [6:0] r;
    int pos;
    s = lit_segments(v);
    r = 7'd0;
    for (int i = 0; i < s.len(); i++) begin
      pos = 6 - (int'(s[i]) - 97);
      r[pos] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] e_cc;
    seg_in = 4'd8;
    blank  = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    e_cc = 7'b0000000;
    total++;
    if (seg_out_cc !== e_cc) begin
      bad++;
      $display("FAIL reset_cc got=%b want=%b", seg_out_cc, e_cc);
    end
    total++;
    if (seg_out_ca !== ~e_cc) begin
      bad++;
      $display("FAIL reset_ca got=%b want=%b", seg_out_ca, ~e_cc);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [6:0] e_cc;
    for (int v = 0; v < 16; v++) begin
      seg_in = 4'(v);
      blank  = 1'b0;
      tick();
      e_cc = glyph(v);
      total++;
      if (seg_out_cc !== e_cc) begin
        bad++;
        $display("FAIL sweep_cc digit=%0d got=%b want=%b", v, seg_out_cc, e_cc);
      end
      total++;
      if (seg_out_ca !== ~e_cc) begin
        bad++;
        $display("FAIL sweep_ca digit=%0d got=%b want=%b", v, seg_out_ca, ~e_cc);
      end
    end
  endtask

  task automatic test_latency();
    seg_in = 4'd3;
    blank  = 1'b0;
    tick();
    seg_in = 4'd7;
    #3;
    total++;
    if (seg_out_cc !== glyph(3)) begin
      bad++;
      $display("FAIL latency_hold got=%b want=%b", seg_out_cc, glyph(3));
    end
    tick();
    total++;
    if (seg_out_cc !== glyph(7)) begin
      bad++;
      $display("FAIL latency_update got=%b want=%b", seg_out_cc, glyph(7));
    end
  endtask

  task automatic test_blank();
    seg_in = 4'd8;
    blank  = 1'b1;
    tick();
    total++;
    if (seg_out_cc !== 7'b0000000) begin
      bad++;
      $display("FAIL blank_cc got=%b want=%b", seg_out_cc, 7'b0000000);
    end
    total++;
    if (seg_out_ca !== 7'b1111111) begin
      bad++;
      $display("FAIL blank_ca got=%b want=%b", seg_out_ca, 7'b1111111);
    end
    blank = 1'b0;
    tick();
    total++;
    if (seg_out_cc !== 7'b1111111) begin
      bad++;
      $display("FAIL unblank_cc got=%b want=%b", seg_out_cc, 7'b1111111);
    end
  endtask

  task automatic test_polarity();
    seg_in = 4'd0;
    blank  = 1'b0;
    tick();
    total++;
    if (seg_out_ca !== 7'b0000001) begin
      bad++;
      $display("FAIL polarity_zero got=%b want=%b", seg_out_ca, 7'b0000001);
    end
    seg_in = 4'd1;
    tick();
    total++;
    if (seg_out_ca !== 7'b1001111) begin
      bad++;
      $display("FAIL polarity_one got=%b want=%b", seg_out_ca, 7'b1001111);
    end
  endtask

  task automatic test_midrun_reset();
    for (int v = 2; v < 9; v++) begin
      seg_in = 4'(v);
      blank  = 1'b0;
      rst    = (v == 5) ? 1'b1 : 1'b0;
      tick();
      if (v == 5) begin
        total++;
        if (seg_out_cc !== 7'b0000000 || seg_out_ca !== 7'b1111111) begin
          bad++;
          $display("FAIL midrun_reset got_cc=%b got_ca=%b want=0000000/1111111",
                   seg_out_cc, seg_out_ca);
        end
      end else begin
        total++;
        if (seg_out_cc !== glyph(v)) begin
          bad++;
          $display("FAIL midrun_resume digit=%0d got=%b want=%b", v, seg_out_cc, glyph(v));
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int v;
    logic b;
    logic r;
    logic [6:0] e_cc;
    for (int n = 0; n < 200; n++) begin
      v = int'($urandom_range(15, 0));
      b = ($urandom_range(3, 0) == 0);
      r = ($urandom_range(15, 0) == 0);
      seg_in = 4'(v);
      blank  = b;
      rst    = r;
      tick();
      e_cc = (r || b) ? 7'b0000000 : glyph(v);
      total++;
      if (seg_out_cc !== e_cc || seg_out_ca !== ~e_cc) begin
        bad++;
        $display("FAIL random n=%0d v=%0d blank=%0d rst=%0d got_cc=%b got_ca=%b want_cc=%b",
                 n, v, b, r, seg_out_cc, seg_out_ca, e_cc);
      end
    end
    rst   = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    seg_in = 4'd0;
    blank  = 1'b0;
    test_reset();
    test_sweep();
    test_latency();
    test_blank();
    test_polarity();
    test_midrun_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
